// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, a consumer and alu_arbiter.
// master: requester/consumer side; slave: arbiter side. rsp_zero exists only
// when ALU_ARB_ZERO_EN is defined.
interface alu_arbiter_if #(
   parameter int N = 32
);
   logic         req0_valid;
   logic         req0_ready;
   logic [N-1:0] req0_a;
   logic [N-1:0] req0_b;
   logic [2:0]   req0_op;
   logic         req1_valid;
   logic         req1_ready;
   logic [N-1:0] req1_a;
   logic [N-1:0] req1_b;
   logic [2:0]   req1_op;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [N-1:0] rsp_result;
   logic         rsp_err;
`ifdef ALU_ARB_ZERO_EN
   logic         rsp_zero;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req0_ready, req1_ready,
      output rsp_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_err, rsp_zero
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req0_ready, req1_ready,
      input  rsp_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_err, rsp_zero
   );
`else
   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req0_ready, req1_ready,
      output rsp_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_err
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req0_ready, req1_ready,
      input  rsp_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_err
   );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter sharing one ALU; IDLE -> EXEC -> RESP per op.
// Ports: clk, rst_n (async active-low), bus (alu_arbiter_if.slave).
// Optional: ALU_ARB_ZERO_EN adds a registered rsp_zero flag.
module alu_arbiter #(
   parameter int N = 32
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic         last_id_q, last_id_d;
   logic [N-1:0] a_q, b_q;
   logic [2:0]   op_q;
   logic         id_q;
   logic [N-1:0] res_q;
   logic         err_q;
   logic         rid_q;
`ifdef ALU_ARB_ZERO_EN
   logic         zero_q;
`endif

   logic         gnt0, gnt1;
   logic         acc0, acc1;
   logic [N-1:0] alu_res;
   logic         alu_err;

   // On a tie the requester not served last wins.
   assign gnt0 = bus.req0_valid && (!bus.req1_valid || last_id_q);
   assign gnt1 = bus.req1_valid && (!bus.req0_valid || !last_id_q);

   assign acc0 = (state_q == IDLE) && gnt0;
   assign acc1 = (state_q == IDLE) && gnt1;

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (op_q)
         3'b010:  alu_res = a_q + b_q;
         3'b110:  alu_res = a_q - b_q;
         3'b000:  alu_res = a_q & b_q;
         3'b001:  alu_res = a_q | b_q;
         3'b111:  alu_res = {{(N-1){1'b0}}, (a_q < b_q)};
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_id_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         last_id_q <= last_id_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_id_d = last_id_q;
      unique case (state_q)
         IDLE: begin
            if (acc0 || acc1) begin
               state_d   = EXEC;
               last_id_d = acc1;
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         id_q  <= 1'b0;
         res_q <= '0;
         err_q <= 1'b0;
         rid_q <= 1'b0;
      end else begin
         if (acc0 || acc1) begin
            a_q  <= acc1 ? bus.req1_a : bus.req0_a;
            b_q  <= acc1 ? bus.req1_b : bus.req0_b;
            op_q <= acc1 ? bus.req1_op : bus.req0_op;
            id_q <= acc1;
         end
         if (state_q == EXEC) begin
            res_q <= alu_res;
            err_q <= alu_err;
            rid_q <= id_q;
         end
      end
   end

`ifdef ALU_ARB_ZERO_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
      end else if (state_q == EXEC) begin
         zero_q <= (alu_res == '0);
      end
   end

   assign bus.rsp_zero = zero_q;
`endif

   always_comb begin
      bus.req0_ready = acc0;
      bus.req1_ready = acc1;
      bus.rsp_valid  = (state_q == RESP);
      bus.rsp_id     = rid_q;
      bus.rsp_result = res_q;
      bus.rsp_err    = err_q;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed ops, queued expectations,
// monitor compares each accepted response.
module tb_alu_arbiter;

   localparam int N = 32;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [2:0]   op;
      logic [N-1:0] r;
      logic         e;
   } op_t;

   typedef struct {
      logic         id;
      logic [N-1:0] r;
      logic         e;
   } exp_t;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   exp_t sb[$];
   op_t  p0[$];
   op_t  p1[$];

   alu_arbiter_if #(.N(N)) bus ();

   alu_arbiter #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [N-1:0] got,
                      input logic [N-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   function automatic op_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic [2:0] op, input logic [N-1:0] r,
                              input logic e);
      op_t o;
      o.a = a; o.b = b; o.op = op; o.r = r; o.e = e;
      return o;
   endfunction

   task automatic push(input logic id, input op_t o);
      exp_t x;
      x.id = id; x.r = o.r; x.e = o.e;
      sb.push_back(x);
   endtask

   // Monitor: compares the held response in the cycle it is accepted.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rsp id=%0d result=%h",
                        bus.rsp_id, bus.rsp_result);
            end else begin
               exp_t x;
               x = sb.pop_front();
               chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, x.id});
               chk("rsp_result", bus.rsp_result, x.r);
               chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, x.e});
`ifdef ALU_ARB_ZERO_EN
               chk("rsp_zero", {31'd0, bus.rsp_zero},
                   {31'd0, (x.r == '0)});
`endif
            end
         end
      end
   end

   task automatic drive(input logic k, input logic v, input op_t o);
      if (k) begin
         bus.req1_valid = v; bus.req1_a = o.a;
         bus.req1_b = o.b;   bus.req1_op = o.op;
      end else begin
         bus.req0_valid = v; bus.req0_a = o.a;
         bus.req0_b = o.b;   bus.req0_op = o.op;
      end
   endtask

   // Single request on port k; called one time unit after a rising edge.
   task automatic issue(input logic k, input op_t o, input bit imm,
                        input bit do_push);
      bit done;
      done = 0;
      drive(k, 1'b1, o);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if ((k ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
            if (imm) chk("accept_latency", c, 0);
            if (do_push) push(k, o);
            done = 1;
         end
         @(posedge clk); #1;
      end
      drive(k, 1'b0, o);
      if (!done) begin
         tests++; fails++;
         $display("FAIL issue_timeout port=%0d got=none exp=accept", k);
      end
   endtask

   // Both ports present their queued ops; checks round-robin order.
   task automatic run_dual(input logic first, input bit imm);
      int   i0, i1, budget, cyc;
      logic want;
      logic v0, v1;
      i0 = 0; i1 = 0; budget = 200; want = first; cyc = 0;
      while ((i0 < p0.size() || i1 < p1.size()) && budget > 0) begin
         v0 = (i0 < p0.size());
         v1 = (i1 < p1.size());
         drive(1'b0, v0, v0 ? p0[i0] : mk(0, 0, 0, 0, 0));
         drive(1'b1, v1, v1 ? p1[i1] : mk(0, 0, 0, 0, 0));
         @(negedge clk);
         if (bus.req0_ready && bus.req1_ready) begin
            tests++; fails++;
            $display("FAIL both_ready got=11 exp=one");
         end
         if (imm && cyc == 0)
            chk("accept_next_cycle",
                {31'd0, bus.req0_ready | bus.req1_ready}, 1);
         if (bus.req0_ready || bus.req1_ready) begin
            logic id;
            id = bus.req1_ready;
            if (v0 && v1) chk("rr_grant", {31'd0, id}, {31'd0, want});
            want = !id;
            if (id) begin push(1'b1, p1[i1]); i1++; end
            else    begin push(1'b0, p0[i0]); i0++; end
         end
         @(posedge clk); #1;
         budget--;
         cyc++;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      if (budget == 0) begin
         tests++; fails++;
         $display("FAIL dual_timeout got=%0d/%0d exp=%0d/%0d",
                  i0, i1, p0.size(), p1.size());
      end
   endtask

   // Wait until all expected responses are consumed, then return in IDLE.
   task automatic drain();
      int b;
      b = 0;
      while (sb.size() != 0 && b < 100) begin
         @(negedge clk);
         b++;
      end
      if (sb.size() != 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout got=%0d exp=0", sb.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      tests = 0; fails = 0;
      rst_n = 1'b0;
      bus.rsp_ready = 1'b0;
      drive(1'b0, 1'b0, mk(0, 0, 0, 0, 0));
      drive(1'b1, 1'b0, mk(0, 0, 0, 0, 0));
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
      chk("rst_rsp_id", {31'd0, bus.rsp_id}, 0);
      chk("rst_rsp_result", bus.rsp_result, 0);
      chk("rst_rsp_err", {31'd0, bus.rsp_err}, 0);
`ifdef ALU_ARB_ZERO_EN
      chk("rst_rsp_zero", {31'd0, bus.rsp_zero}, 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single add, with response latency check.
      bus.rsp_ready = 1'b1;
      issue(1'b0, mk(5, 3, 3'b010, 8, 0), 1, 1);
      @(negedge clk);
      chk("exec_no_valid", {31'd0, bus.rsp_valid}, 0);
      @(negedge clk);
      chk("resp_valid_T2", {31'd0, bus.rsp_valid}, 1);
      drain();

      // Fresh reset, then both valid: strict alternation over 6 ops.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      p0 = {mk(3, 5, 3'b110, 32'hFFFF_FFFE, 0),
            mk(10, 20, 3'b010, 30, 0),
            mk(32'hFF00, 32'h0FF0, 3'b000, 32'h0F00, 0)};
      p1 = {mk(2, 7, 3'b111, 1, 0),
            mk(32'h0A, 32'h50, 3'b001, 32'h5A, 0),
            mk(100, 1, 3'b110, 99, 0)};
      run_dual(1'b0, 1);
      drain();

      // Unsupported op.
      issue(1'b1, mk(9, 9, 3'b011, 0, 1), 1, 1);
      drain();

      // Backpressure stall with both requesters waiting.
      bus.rsp_ready = 1'b0;
      issue(1'b0, mk(1, 1, 3'b010, 2, 0), 1, 1);
      p0 = {mk(32'h10, 32'h01, 3'b001, 32'h11, 0)};
      p1 = {mk(32'hFF, 32'h0F, 3'b000, 32'h0F, 0)};
      drive(1'b0, 1'b1, p0[0]);
      drive(1'b1, 1'b1, p1[0]);
      @(negedge clk);
      chk("exec_ready0", {31'd0, bus.req0_ready}, 0);
      chk("exec_ready1", {31'd0, bus.req1_ready}, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, bus.rsp_valid}, 1);
         chk("stall_result", bus.rsp_result, 2);
         chk("stall_id", {31'd0, bus.rsp_id}, 0);
         chk("stall_ready0", {31'd0, bus.req0_ready}, 0);
         chk("stall_ready1", {31'd0, bus.req1_ready}, 0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      run_dual(1'b1, 1);
      drain();

      // Reset while in EXEC: response must be discarded.
      issue(1'b0, mk(7, 7, 3'b010, 14, 0), 1, 0);
      rst_n = 1'b0;
      #1;
      chk("rst_exec_valid", {31'd0, bus.rsp_valid}, 0);
      chk("rst_exec_result", bus.rsp_result, 0);
      chk("rst_exec_id", {31'd0, bus.rsp_id}, 0);
      chk("rst_exec_err", {31'd0, bus.rsp_err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Edge arithmetic; req0 must win the post-reset tie.
      p0 = {mk(32'hFFFF_FFFF, 1, 3'b010, 0, 0),
            mk(32'h8000_0000, 1, 3'b111, 0, 0)};
      p1 = {mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0, 0),
            mk(32'hF000_0000, 32'h0000_000F, 3'b001, 32'hF000_000F, 0)};
      run_dual(1'b0, 1);
      drain();

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
